aeolus_cpu_top: RTL and testbench
=================================

AEOLUS_CPU_TOP -- requirements
Module: aeolus_cpu_top

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named boardCLK and reset as the codebase does.
REQ-002 boardCLK  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 forces the reset state immediately, 1 runs.
REQ-004 switches  input  8  user data; sampled by the LDSW instruction.
REQ-005 cpuOut  output  8  registered output port; written only by the OUT instruction.
REQ-006 ROM_INIT  parameter, default "" (built-in program)  optional hex file for the 256x16 program ROM.

Function
REQ-007 SHALL be an 8-bit accumulator CPU with these state elements: 8-bit PC, 8-bit accumulator A, flags Z and C, 16x8 data RAM, and 8-bit output register.
REQ-008 SHALL fetch from a combinational 256x16 ROM addressed by PC; instruction format: [15:12] opcode, [11:8] ignored, [7:0] imm; RAM address = imm[3:0].
REQ-009 SHALL execute one instruction per rising edge; default PC update is PC+1, wrapping 255->0.
REQ-010 SHALL implement opcode 0 NOP: no state change except PC.
REQ-011 SHALL implement opcode 1 LDI: A=imm.
REQ-012 SHALL implement opcode 2 LDSW: A=switches.
REQ-013 SHALL implement opcode 3 LD: A=RAM[a].
REQ-014 SHALL implement opcode 4 ST: RAM[a]=A.
REQ-015 SHALL implement opcodes 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR: A = A op RAM[a].
REQ-016 SHALL implement opcode A ADDI: A=A+imm.
REQ-017 SHALL implement opcode B OUT: cpuOut=A.
REQ-018 SHALL implement opcode C JMP: PC=imm.
REQ-019 SHALL implement opcode D JZ: PC=imm if Z, else PC+1.
REQ-020 SHALL implement opcode E JC: PC=imm if C, else PC+1.
REQ-021 SHALL implement opcode F HALT: PC holds and all state is frozen until reset.
REQ-022 SHALL set Z=(result==0) on opcodes 5-A; Z SHALL be unchanged on all other opcodes.
REQ-023 SHALL set C on ADD/ADDI to bit 8 of the 9-bit sum, on SUB to borrow (1 when A<operand), and to 0 on AND/OR/XOR; C SHALL be unchanged on all other opcodes.
REQ-024 SHALL wrap arithmetic results modulo 256.
REQ-025 SHALL make a loaded A value visible to the next instruction (no hazards, single-cycle).
REQ-026 SHALL hold cpuOut between OUT instructions; a later OUT overwrites it.
REQ-027 SHALL use this built-in default program when ROM_INIT="": 0:LDSW, 1:ADDI 0x37, 2:OUT, 3:HALT; all remaining ROM words are 0x0000 (NOP).

Reset
REQ-028 SHALL, while reset=0, hold PC=0, A=0, Z=0, C=0, all RAM words=0, and cpuOut=0.
REQ-029 SHALL abort any program on assertion of reset mid-operation; the first instruction after release SHALL be fetched from address 0.
REQ-030 SHALL release a HALT state only by reset.

Verification
REQ-031 SHALL pass: default program, switches=0xAA, reset released -> cpuOut=0x00 for 2 edges, then 0xE1 (225) after the 3rd edge, stable thereafter (PC=3).
REQ-032 SHALL pass: default program, switches=0xFF -> cpuOut=0x36 and C=1 after ADDI.
REQ-033 SHALL pass: program LDI 0x05, ST 0, LDI 0x05, SUB 0, JZ 6, OUT, OUT, HALT -> Z=1 and C=0; cpuOut=0x00.
REQ-034 SHALL pass: program LDI 0x01, SUB 0 (RAM=0 after reset)... with LDI 0x00 then SUB with RAM[0]=1 -> A=0xFF, C=1, Z=0.
REQ-035 SHALL pass: reset asserted asynchronously mid-program, between clock edges -> PC, A, and cpuOut are 0 immediately, and execution restarts at 0.
REQ-036 SHALL pass: JMP 0xFF reached with ROM[255]=NOP -> PC wraps to 0x00.

Source files
------------

// File: rtl/aeolus_cpu_top.sv
// ----------------------------------------------------------------------------
// aeolus_cpu_top
//   8-bit accumulator CPU. Single-cycle: each rising edge of boardCLK fetches
//   ROM[PC] (combinational) and retires it. State: PC, A, flags Z/C, a 16x8
//   data RAM and the registered output port.
//
// Ports
//   boardCLK  in   1  system clock, rising edge
//   reset     in   1  asynchronous active-low reset
//   switches  in   8  user data, sampled by LDSW
//   cpuOut    out  8  output register, written only by OUT
//
// Parameters
//   ROM_INIT   "" selects the built-in program. A non-empty value names the
//              hex source of the program; the build flow converts that file
//              into ROM_IMAGE, which then supplies the ROM contents.
//   ROM_IMAGE  256x16 program image, word 0 in the low 16 bits.
//
// Instruction: [15:12] opcode, [11:8] ignored, [7:0] imm, RAM addr = imm[3:0]
// ----------------------------------------------------------------------------
module aeolus_cpu_top #(
    parameter string               ROM_INIT  = "",
    parameter logic [255:0][15:0]  ROM_IMAGE = '0
) (
    input  logic       boardCLK,
    input  logic       reset,
    input  logic [7:0] switches,
    output logic [7:0] cpuOut
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LDSW = 4'h2, OP_LD  = 4'h3,
        OP_ST   = 4'h4, OP_ADD = 4'h5, OP_SUB  = 4'h6, OP_AND = 4'h7,
        OP_OR   = 4'h8, OP_XOR = 4'h9, OP_ADDI = 4'hA, OP_OUT = 4'hB,
        OP_JMP  = 4'hC, OP_JZ  = 4'hD, OP_JC   = 4'hE, OP_HALT = 4'hF
    } opcode_e;

    // Built-in program: LDSW, ADDI 0x37, OUT, HALT, rest NOP.
    localparam logic [255:0][15:0] BUILTIN_ROM =
        {{252{16'h0000}}, 16'hF000, 16'hB000, 16'hA037, 16'h2000};
    localparam logic [255:0][15:0] ROM_CONTENT =
        (ROM_INIT == "") ? BUILTIN_ROM : ROM_IMAGE;

    logic [7:0]       pc_q, pc_d;
    logic [7:0]       a_q, a_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic [7:0]       out_q, out_d;
    logic [15:0][7:0] ram_q;

    logic [15:0] instr;
    opcode_e     op;
    logic [7:0]  imm;
    logic [3:0]  addr;
    logic [7:0]  mem;
    logic        ram_we;
    logic [8:0]  sum;
    logic [8:0]  diff;

    assign instr = ROM_CONTENT[pc_q];
    assign op    = opcode_e'(instr[15:12]);
    assign imm   = instr[7:0];
    assign addr  = imm[3:0];
    assign mem   = ram_q[addr];

    // Bits [11:8] carry no meaning in this ISA.
    logic unused_instr;
    assign unused_instr = ^instr[11:8];

    // Shared adders; bit 8 gives carry on add and borrow on subtract.
    assign sum  = {1'b0, a_q} + {1'b0, (op == OP_ADDI) ? imm : mem};
    assign diff = {1'b0, a_q} - {1'b0, mem};

    always_comb begin
        pc_d   = pc_q + 8'd1;
        a_d    = a_q;
        z_d    = z_q;
        c_d    = c_q;
        out_d  = out_q;
        ram_we = 1'b0;
        unique case (op)
            OP_NOP:  ;
            OP_LDI:  a_d = imm;
            OP_LDSW: a_d = switches;
            OP_LD:   a_d = mem;
            OP_ST:   ram_we = 1'b1;
            OP_ADD, OP_ADDI: begin
                a_d = sum[7:0];
                c_d = sum[8];
                z_d = (sum[7:0] == 8'h00);
            end
            OP_SUB: begin
                a_d = diff[7:0];
                c_d = diff[8];
                z_d = (diff[7:0] == 8'h00);
            end
            OP_AND: begin
                a_d = a_q & mem;
                c_d = 1'b0;
                z_d = ((a_q & mem) == 8'h00);
            end
            OP_OR: begin
                a_d = a_q | mem;
                c_d = 1'b0;
                z_d = ((a_q | mem) == 8'h00);
            end
            OP_XOR: begin
                a_d = a_q ^ mem;
                c_d = 1'b0;
                z_d = ((a_q ^ mem) == 8'h00);
            end
            OP_OUT:  out_d = a_q;
            OP_JMP:  pc_d = imm;
            OP_JZ:   if (z_q) pc_d = imm;
            OP_JC:   if (c_q) pc_d = imm;
            // Holding PC re-executes HALT forever, freezing everything.
            OP_HALT: pc_d = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge boardCLK or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            a_q   <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            out_q <= '0;
            ram_q <= '0;
        end else begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            z_q   <= z_d;
            c_q   <= c_d;
            out_q <= out_d;
            if (ram_we) ram_q[addr] <= a_q;
        end
    end

    assign cpuOut = out_q;

endmodule

// File: tb/tb_aeolus_cpu_top.sv
module tb_aeolus_cpu_top;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw0, sw1;
    logic [7:0] out0, out1, out2, out3, out4, out5;

    int checks = 0;
    int errors = 0;

    // Programs, word 0 last in each concatenation.
    localparam logic [255:0][15:0] P_JZ =
        {{248{16'h0}}, 16'hF000, 16'hB000, 16'hB000, 16'hD006,
         16'h6000, 16'h1005, 16'h4000, 16'h1005};
    localparam logic [255:0][15:0] P_BORROW =
        {{250{16'h0}}, 16'hF000, 16'hB000, 16'h6000, 16'h1000,
         16'h4000, 16'h1001};
    localparam logic [255:0][15:0] P_WRAP = {{255{16'h0}}, 16'hC0FF};
    localparam logic [255:0][15:0] P_ALU =
        {{242{16'h0}}, 16'hF000, 16'hB000, 16'h3001, 16'h9001,
         16'h8001, 16'h7001, 16'h103C, 16'hF000, 16'hE007,
         16'hA001, 16'h5001, 16'h10F0, 16'h4001, 16'h100F};

    aeolus_cpu_top d0 (.boardCLK(clk), .reset(rst_n), .switches(sw0),   .cpuOut(out0));
    aeolus_cpu_top d1 (.boardCLK(clk), .reset(rst_n), .switches(sw1),   .cpuOut(out1));
    aeolus_cpu_top #(.ROM_INIT("jz"),     .ROM_IMAGE(P_JZ))
        d2 (.boardCLK(clk), .reset(rst_n), .switches(8'h00), .cpuOut(out2));
    aeolus_cpu_top #(.ROM_INIT("borrow"), .ROM_IMAGE(P_BORROW))
        d3 (.boardCLK(clk), .reset(rst_n), .switches(8'h00), .cpuOut(out3));
    aeolus_cpu_top #(.ROM_INIT("wrap"),   .ROM_IMAGE(P_WRAP))
        d4 (.boardCLK(clk), .reset(rst_n), .switches(8'h00), .cpuOut(out4));
    aeolus_cpu_top #(.ROM_INIT("alu"),    .ROM_IMAGE(P_ALU))
        d5 (.boardCLK(clk), .reset(rst_n), .switches(8'h00), .cpuOut(out5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sw0   = 8'hAA;
        sw1   = 8'hFF;
        step(2);

        // Reset state held across edges
        chk("rst_pc",  {8'h0, d0.pc_q}, 16'h0000);
        chk("rst_a",   {8'h0, d0.a_q},  16'h0000);
        chk("rst_zc",  {14'h0, d0.z_q, d0.c_q}, 16'h0000);
        chk("rst_out", {8'h0, out0},    16'h0000);
        chk("rst_ram", d5.ram_q[1] | d5.ram_q[15], 16'h0000);
        chk("rst_pc_wrap", {8'h0, d4.pc_q}, 16'h0000);

        rst_n = 1'b1;
        step(1);   // edge 1
        chk("e1_out0", {8'h0, out0}, 16'h0000);
        chk("e1_a0",   {8'h0, d0.a_q}, 16'h00AA);
        chk("e1_wrap_pc", {8'h0, d4.pc_q}, 16'h00FF);

        step(1);   // edge 2
        chk("e2_out0", {8'h0, out0}, 16'h0000);
        chk("e2_a0",   {8'h0, d0.a_q}, 16'h00E1);
        chk("e2_c0",   {15'h0, d0.c_q}, 16'h0000);
        chk("e2_a1",   {8'h0, d1.a_q}, 16'h0036);
        chk("e2_c1",   {15'h0, d1.c_q}, 16'h0001);
        chk("e2_z1",   {15'h0, d1.z_q}, 16'h0000);
        chk("e2_wrap_pc", {8'h0, d4.pc_q}, 16'h0000);

        step(1);   // edge 3
        chk("e3_out0", {8'h0, out0}, 16'h00E1);
        chk("e3_out1", {8'h0, out1}, 16'h0036);

        step(2);   // edge 5
        chk("e5_pc0_halt", {8'h0, d0.pc_q}, 16'h0003);
        chk("e5_alu_a",    {8'h0, d5.a_q}, 16'h0000);
        chk("e5_alu_zc",   {14'h0, d5.z_q, d5.c_q}, 16'h0003);

        step(8);   // edge 13
        chk("halt_out0", {8'h0, out0}, 16'h00E1);
        chk("halt_pc0",  {8'h0, d0.pc_q}, 16'h0003);
        chk("halt_a0",   {8'h0, d0.a_q}, 16'h00E1);
        chk("jz_pc",   {8'h0, d2.pc_q}, 16'h0007);
        chk("jz_zc",   {14'h0, d2.z_q, d2.c_q}, 16'h0002);
        chk("jz_out",  {8'h0, out2}, 16'h0000);
        chk("jz_ram0", {8'h0, d2.ram_q[0]}, 16'h0005);
        chk("bor_a",   {8'h0, d3.a_q}, 16'h00FF);
        chk("bor_zc",  {14'h0, d3.z_q, d3.c_q}, 16'h0001);
        chk("bor_out", {8'h0, out3}, 16'h00FF);
        chk("bor_pc",  {8'h0, d3.pc_q}, 16'h0005);
        chk("alu_pc",  {8'h0, d5.pc_q}, 16'h000D);
        chk("alu_a",   {8'h0, d5.a_q}, 16'h000F);
        chk("alu_zc",  {14'h0, d5.z_q, d5.c_q}, 16'h0002);
        chk("alu_out", {8'h0, out5}, 16'h000F);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",  {8'h0, d0.pc_q}, 16'h0000);
        chk("arst_a",   {8'h0, d0.a_q},  16'h0000);
        chk("arst_out", {8'h0, out0},    16'h0000);
        chk("arst_ram", {8'h0, d2.ram_q[0]}, 16'h0000);

        @(negedge clk);
        sw0   = 8'h10;
        rst_n = 1'b1;
        step(1);
        chk("restart_pc", {8'h0, d0.pc_q}, 16'h0001);
        chk("restart_a",  {8'h0, d0.a_q},  16'h0010);
        step(2);
        chk("restart_out", {8'h0, out0}, 16'h0047);
        chk("restart_pc3", {8'h0, d0.pc_q}, 16'h0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
